frac_search_ctrl: RTL and testbench
===================================

Name: frac_search_ctrl

Overview:
- Sequencer for the 8x8 quarter-pel search datapath (frac_search).
- Accepts block requests on a valid/ready handshake and holds at most one pending request.
- Reads the current and original 8x8 blocks line by line from two synchronous line buffers, and drives cur_pix/org_pix/ready with the exact line skew the datapath requires.
- Captures mvx/mvy and reports them with a one-cycle done pulse, tagged with the block index.

Parameters:
- BLK_W, 4, width of block index; each buffer holds 2^BLK_W blocks of 8 lines x 64 bits.
- ADDR_W, BLK_W+3, line-buffer address width; address = {blk_idx, line[2:0]}.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  block request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_blk  in  BLK_W  block index of request
- abort  in  1  cancel current and pending work
- cur_rd_en  out  1  current-block buffer read enable
- cur_addr  out  ADDR_W  current-block line address
- cur_rdata  in  64  current line, valid one cycle after cur_rd_en
- org_rd_en  out  1  original-block buffer read enable
- org_addr  out  ADDR_W  original-block line address
- org_rdata  in  64  original line, valid one cycle after org_rd_en
- fs_cur_pix  out  64  to datapath cur_pix; equals cur_rdata
- fs_org_pix  out  48  to datapath org_pix; equals org_rdata[55:8]
- fs_ready  out  1  to datapath ready
- fs_reset  out  1  active-high datapath reset
- fs_mvx  in  3  datapath result
- fs_mvy  in  3  datapath result
- done  out  1  one-cycle result strobe
- mvx  out  3  captured result, held until next done
- mvy  out  3  captured result, held until next done
- res_blk  out  BLK_W  block index of captured result
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n low, asynchronous):
  - State IDLE; pending slot empty.
  - All read enables, fs_ready and done are 0; mvx, mvy, res_blk and addresses are 0.
  - fs_reset = 1 combinationally while reset_n is low.
- States: IDLE, FEED, RSLT, CAPT.
- IDLE: if the pending slot is full, start its block (slot empties); else if req_valid, start req_blk. The start cycle is T, which is the first FEED cycle.
- FEED spans T..T+7. Line counter k = 0..7.
  - Cycle T+k: cur_rd_en = 1, cur_addr = {blk, k}.
  - Cycles T+2..T+7: org_rd_en = 1, org_addr = {blk, k-1}, i.e. original lines 1..6. Original lines 0 and 7 are never read.
- fs_ready is cur_rd_en delayed one cycle, so it is high exactly for T+1..T+8.
  - T+1 carries current line 0.
  - T+3..T+8 carry current lines 2..7 together with original lines 1..6.
  - fs_org_pix is don't-care outside T+3..T+8.
- RSLT covers T+8..T+9: the last line is presented, then the datapath result cycle. fs_ready is 0 at T+9.
- CAPT at T+10: register fs_mvx/fs_mvy/blk into mvx/mvy/res_blk at the T+10 edge. done = 1 during T+11 only. The state is IDLE in T+11.
- A new block may start in T+11, the same cycle done is high. Its fs_ready then rises at T+12, which meets the datapath's need for at least two idle cycles after the last line.
- req_ready = !pending_full.
  - A request accepted while busy fills the pending slot.
  - A request accepted in IDLE with an empty slot starts directly.
  - A request accepted in the same cycle the pending entry launches goes into the slot.
- abort (any state):
  - Next cycle: IDLE, pending slot cleared, fs_reset = 1 for exactly one cycle, no done, mvx/mvy/res_blk unchanged.
  - req_valid is ignored in the abort cycle.
  - abort in IDLE still pulses fs_reset.
- Reset mid-FEED: all reads stop immediately and fs_ready drops; the datapath is reset through fs_reset.
- Counter wraps 7 -> 0 only on the FEED -> RSLT transition; no other wrap exists.

Decomposition:
- Shared package (frac_pkg): LINES_PER_BLK = 8, PIX_W = 8, LINE_W = 64, ORG_LINE_FIRST = 1, ORG_LINE_LAST = 6, state encoding constants, MV_W = 3.
- One sub-module, frac_req_slot: the one-entry pending request register with valid/ready and clear.
- FSM, address generation and result capture stay in frac_search_ctrl.

Test Plan:
- Single request blk=3, buffers filled with known patterns:
  - cur_addr runs 0x18..0x1F on T..T+7; org_addr runs 0x19..0x1E on T+2..T+7; fs_ready is high T+1..T+8.
  - done is high at T+11 with res_blk=3 and mvx/mvy equal to the reference model result (identical blocks give mvx=2, mvy=2).
- Back-to-back requests blk=1 then blk=2, the second sent at T+1:
  - req_ready drops after the second request is accepted.
  - The second block's cur_rd_en starts at T+11; two done pulses, 11 cycles apart.
- Third request while the slot is full: req_ready=0 and the request is held. It is accepted in the cycle the pending entry launches.
- abort at T+4:
  - Reads stop and fs_reset pulses at T+5.
  - The pending request is dropped; no done; mvx/mvy keep their previous values.
- reset_n low at T+6 for 3 cycles: outputs go to reset values asynchronously and fs_reset=1. A fresh request after release completes normally.
- Request in the done cycle: the new start occurs at T+11, and fs_ready for the new block first rises at T+12.

Source files
------------

// File: rtl/frac_pkg.sv
// Shared constants and state encoding for the quarter-pel search sequencer.
package frac_pkg;

   localparam int LINES_PER_BLK = 8;
   localparam int PIX_W         = 8;
   localparam int LINE_W        = 64;
   localparam int MV_W          = 3;

   // Original lines 0 and 7 are never needed by the datapath.
   localparam logic [2:0] ORG_LINE_FIRST = 3'd1;
   localparam logic [2:0] ORG_LINE_LAST  = 3'd6;
   localparam logic [2:0] LAST_LINE      = 3'(LINES_PER_BLK - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FEED = 2'd1,
      ST_RSLT = 2'd2,
      ST_CAPT = 2'd3
   } state_t;

endpackage

// File: rtl/frac_req_slot.sv
// One-entry pending request register.
// Handshake: a word transfers on a clock edge where in_valid && in_ready.
// in_ready is high when the slot is empty or is being drained (pop) in the
// same cycle, so a launch and a refill can share one cycle.
module frac_req_slot #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         pop,
   input  logic         clear,
   output logic         full,
   output logic [W-1:0] data
);

   assign in_ready = !full || pop;

   // Slot occupancy and payload; clear wins, then refill, then drain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         full <= 1'b0;
         data <= '0;
      end else if (clear) begin
         full <= 1'b0;
      end else if (in_valid && in_ready) begin
         full <= 1'b1;
         data <= in_data;
      end else if (pop) begin
         full <= 1'b0;
      end
   end

endmodule

// File: rtl/frac_search_ctrl.sv
// Sequencer for the 8x8 quarter-pel search datapath: reads current/original
// lines from two synchronous line buffers with the skew the datapath needs
// and captures its motion-vector result.
// Request handshake: a request transfers on a clock edge where
// req_valid && req_ready; req_ready never depends on req_valid.
// A block launches combinationally from IDLE (cycle T reads current line 0),
// so the state register reads FEED from T+1 and busy follows the register.
module frac_search_ctrl
   import frac_pkg::*;
#(
   parameter int BLK_W  = 4,
   parameter int ADDR_W = BLK_W + 3
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [BLK_W-1:0]  req_blk,
   input  logic              abort,
   output logic              cur_rd_en,
   output logic [ADDR_W-1:0] cur_addr,
   input  logic [LINE_W-1:0] cur_rdata,
   output logic              org_rd_en,
   output logic [ADDR_W-1:0] org_addr,
   input  logic [LINE_W-1:0] org_rdata,
   output logic [LINE_W-1:0] fs_cur_pix,
   output logic [47:0]       fs_org_pix,
   output logic              fs_ready,
   output logic              fs_reset,
   input  logic [MV_W-1:0]   fs_mvx,
   input  logic [MV_W-1:0]   fs_mvy,
   output logic              done,
   output logic [MV_W-1:0]   mvx,
   output logic [MV_W-1:0]   mvy,
   output logic [BLK_W-1:0]  res_blk,
   output logic              busy,
   output logic [1:0]        state_dbg
);

   state_t           state, state_nxt;
   logic [2:0]       cnt;
   logic [2:0]       org_ln;
   logic             res_ph;
   logic             abort_q;
   logic [BLK_W-1:0] blk;
   logic             slot_full, slot_ready, slot_in_valid;
   logic [BLK_W-1:0] slot_blk;
   logic             go_ok, idle, launch_pend, launch_req, start;
   logic [BLK_W-1:0] start_blk;
   logic             unused_org_edges;

   assign idle        = (state == ST_IDLE);
   assign go_ok       = reset_n && !abort;
   assign launch_pend = idle && slot_full && go_ok;
   assign launch_req  = idle && !slot_full && req_valid && go_ok;
   assign start       = launch_pend || launch_req;
   assign start_blk   = slot_full ? slot_blk : req_blk;

   assign req_ready     = slot_ready && go_ok;
   assign slot_in_valid = req_valid && go_ok && !launch_req;

   frac_req_slot #(.W(BLK_W)) u_slot (
      .clk      (clk),
      .reset_n  (reset_n),
      .in_valid (slot_in_valid),
      .in_ready (slot_ready),
      .in_data  (req_blk),
      .pop      (launch_pend),
      .clear    (abort),
      .full     (slot_full),
      .data     (slot_blk)
   );

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_IDLE;
      else          state <= state_nxt;
   end

   // Next-state: abort returns to IDLE from anywhere.
   always_comb begin
      state_nxt = state;
      if (abort) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: if (start) state_nxt = ST_FEED;
            ST_FEED: if (cnt == LAST_LINE) state_nxt = ST_RSLT;
            ST_RSLT: if (res_ph) state_nxt = ST_CAPT;
            ST_CAPT: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // Line-buffer reads: current line k at T+k, original line k-1 at T+k.
   always_comb begin
      cur_rd_en = 1'b0;
      cur_addr  = '0;
      org_rd_en = 1'b0;
      org_addr  = '0;
      org_ln    = cnt - 3'd1;
      if (start) begin
         cur_rd_en = 1'b1;
         cur_addr  = {start_blk, 3'd0};
      end else if (state == ST_FEED) begin
         cur_rd_en = 1'b1;
         cur_addr  = {blk, cnt};
         if (org_ln >= ORG_LINE_FIRST && org_ln <= ORG_LINE_LAST) begin
            org_rd_en = 1'b1;
            org_addr  = {blk, org_ln};
         end
      end
   end

   // Line counter, block tag, datapath strobes and result capture.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt      <= 3'd0;
         res_ph   <= 1'b0;
         blk      <= '0;
         fs_ready <= 1'b0;
         abort_q  <= 1'b0;
         done     <= 1'b0;
         mvx      <= '0;
         mvy      <= '0;
         res_blk  <= '0;
      end else begin
         fs_ready <= cur_rd_en;
         abort_q  <= abort;
         done     <= (state == ST_CAPT) && !abort;
         if (abort) begin
            cnt    <= 3'd0;
            res_ph <= 1'b0;
         end else begin
            if (start) begin
               blk <= start_blk;
               cnt <= 3'd1;
            end else if (state == ST_FEED) begin
               cnt <= cnt + 3'd1;   // 7 -> 0 exactly on FEED -> RSLT
            end
            if (state == ST_RSLT) res_ph <= !res_ph;
            if (state == ST_CAPT) begin
               mvx     <= fs_mvx;
               mvy     <= fs_mvy;
               res_blk <= blk;
            end
         end
      end
   end

   assign fs_reset   = !reset_n || abort_q;
   assign fs_cur_pix = cur_rdata;
   assign fs_org_pix = org_rdata[LINE_W-PIX_W-1:PIX_W];
   assign busy       = !idle;
   assign state_dbg  = state;

   assign unused_org_edges = ^{org_rdata[LINE_W-1:LINE_W-PIX_W], org_rdata[PIX_W-1:0]};

endmodule

// File: tb/tb_frac_search_ctrl.sv
// Bench for frac_search_ctrl: line-buffer models, a datapath stub that
// derives a motion vector from the block it is fed, and a result scoreboard.
module tb_frac_search_ctrl;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_blk;
  logic        abort;
  logic        cur_rd_en;
  logic [6:0]  cur_addr;
  logic [63:0] cur_rdata;
  logic        org_rd_en;
  logic [6:0]  org_addr;
  logic [63:0] org_rdata;
  logic [63:0] fs_cur_pix;
  logic [47:0] fs_org_pix;
  logic        fs_ready;
  logic        fs_reset;
  logic [2:0]  fs_mvx;
  logic [2:0]  fs_mvy;
  logic        done;
  logic [2:0]  mvx;
  logic [2:0]  mvy;
  logic [3:0]  res_blk;
  logic        busy;
  logic [1:0]  state_dbg;

  int n_pass;
  int n_total;
  logic [9:0] exp_q[$];
  logic [9:0] last_exp;
  logic       rdy_prev;

  frac_search_ctrl #(.BLK_W(4), .ADDR_W(7)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_blk(req_blk), .abort(abort), .cur_rd_en(cur_rd_en), .cur_addr(cur_addr),
    .cur_rdata(cur_rdata), .org_rd_en(org_rd_en), .org_addr(org_addr),
    .org_rdata(org_rdata), .fs_cur_pix(fs_cur_pix), .fs_org_pix(fs_org_pix),
    .fs_ready(fs_ready), .fs_reset(fs_reset), .fs_mvx(fs_mvx), .fs_mvy(fs_mvy),
    .done(done), .mvx(mvx), .mvy(mvy), .res_blk(res_blk), .busy(busy),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- environment models ----------------
  function automatic logic [63:0] cur_line(input logic [6:0] a);
    cur_line = {8{1'b0, a}};
  endfunction

  function automatic logic [63:0] org_line(input logic [6:0] a);
    for (int i = 0; i < 8; i++) org_line[i*8 +: 8] = {1'b1, a} + 8'(i * 3);
  endfunction

  function automatic logic [5:0] mv_of(input logic [3:0] b);
    mv_of = {b[2:0] ^ 3'd1, b[2:0] - 3'd1};
  endfunction

  // synchronous line buffers, one-cycle read latency
  always @(posedge clk) begin
    if (cur_rd_en) cur_rdata <= cur_line(cur_addr);
    if (org_rd_en) org_rdata <= org_line(org_addr);
  end

  // datapath stub: result depends on the block seen on the first presented line
  always @(posedge clk) begin
    rdy_prev <= fs_ready;
    if (fs_ready && !rdy_prev) {fs_mvx, fs_mvy} <= mv_of(fs_cur_pix[6:3]);
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (reset_n && done) begin
      n_total++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_done: got %h required none", {res_blk, mvx, mvy});
      end else begin
        last_exp = exp_q.pop_front();
        if ({res_blk, mvx, mvy} !== last_exp)
          $display("FAIL sb_result: got %h required %h", {res_blk, mvx, mvy}, last_exp);
        else n_pass++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      req_valid = 1'b0;
      abort = 1'b0;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0; req_valid = 1'b1; req_blk = 4'd3; abort = 1'b0;
    repeat (3) @(negedge clk);
    n_total++;
    if ({cur_rd_en, org_rd_en, fs_ready, done, cur_addr, org_addr, mvx, mvy, res_blk, fs_reset, busy, state_dbg}
        !== {1'b0, 1'b0, 1'b0, 1'b0, 7'd0, 7'd0, 3'd0, 3'd0, 4'd0, 1'b1, 1'b0, 2'd0})
      $display("FAIL reset_outputs: got en=%b%b rdy=%b done=%b ca=%h oa=%h mv=%h/%h rb=%h fsr=%b busy=%b st=%h",
               cur_rd_en, org_rd_en, fs_ready, done, cur_addr, org_addr, mvx, mvy, res_blk, fs_reset, busy, state_dbg);
    else n_pass++;
    cyc();
    reset_n = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    n_total++;
    if ({fs_reset, busy, req_ready} !== 3'b001)
      $display("FAIL reset_release: got fsr/busy/rdy=%b required 001", {fs_reset, busy, req_ready});
    else n_pass++;
  endtask

  task automatic test_single();
    logic [17:0] obs, expv;
    logic [63:0] ol;
    exp_q.push_back({4'd3, mv_of(4'd3)});
    for (int c = 0; c <= 12; c++) begin
      cyc();
      req_valid = (c == 0); req_blk = 4'd3;
      @(negedge clk);
      obs  = {cur_rd_en, cur_addr, org_rd_en, org_addr, fs_ready, done};
      expv = {(c <= 7), (c <= 7) ? {4'd3, 3'(c)} : 7'd0,
              (c >= 2 && c <= 7), (c >= 2 && c <= 7) ? {4'd3, 3'(c - 1)} : 7'd0,
              (c >= 1 && c <= 8), (c == 11)};
      n_total++;
      if (obs !== expv) $display("FAIL single_seq c=%0d: got %h required %h", c, obs, expv);
      else n_pass++;
      if (c >= 1 && c <= 8) begin
        n_total++;
        if (fs_cur_pix !== cur_line({4'd3, 3'(c - 1)}))
          $display("FAIL single_cur_pix c=%0d: got %h required %h", c, fs_cur_pix, cur_line({4'd3, 3'(c - 1)}));
        else n_pass++;
      end
      if (c >= 3 && c <= 8) begin
        ol = org_line({4'd3, 3'(c - 2)});
        n_total++;
        if (fs_org_pix !== ol[55:8])
          $display("FAIL single_org_pix c=%0d: got %h required %h", c, fs_org_pix, ol[55:8]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c <= 36; c++) begin
      cyc();
      req_valid = (c <= 11);
      req_blk   = (c == 0) ? 4'd1 : (c == 1) ? 4'd2 : 4'd5;
      if (c == 0)  exp_q.push_back({4'd1, mv_of(4'd1)});
      if (c == 1)  exp_q.push_back({4'd2, mv_of(4'd2)});
      if (c == 11) exp_q.push_back({4'd5, mv_of(4'd5)});
      @(negedge clk);
      if (c >= 1 && c <= 12) begin
        n_total++;
        if (req_ready !== (c == 1 || c == 11))
          $display("FAIL b2b_req_ready c=%0d: got %b required %b", c, req_ready, (c == 1 || c == 11));
        else n_pass++;
      end
      if (c == 11 || c == 22) begin
        n_total++;
        if ({cur_rd_en, cur_addr} !== {1'b1, (c == 11) ? 4'd2 : 4'd5, 3'd0})
          $display("FAIL b2b_launch c=%0d: got %b/%h", c, cur_rd_en, cur_addr);
        else n_pass++;
      end
      n_total++;
      if (done !== (c == 11 || c == 22 || c == 33))
        $display("FAIL b2b_done c=%0d: got %b required %b", c, done, (c == 11 || c == 22 || c == 33));
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    logic [9:0] prev;
    prev = last_exp;
    for (int c = 0; c <= 25; c++) begin
      cyc();
      req_valid = (c <= 1);
      req_blk   = (c == 0) ? 4'd6 : 4'd7;
      abort     = (c == 4);
      @(negedge clk);
      if (c >= 5) begin
        n_total++;
        if ({cur_rd_en, org_rd_en, busy, done} !== 4'b0000)
          $display("FAIL abort_quiet c=%0d: got en=%b%b busy=%b done=%b", c, cur_rd_en, org_rd_en, busy, done);
        else n_pass++;
      end
      if (c >= 3 && c <= 6) begin
        n_total++;
        if (fs_reset !== (c == 5)) $display("FAIL abort_fs_reset c=%0d: got %b required %b", c, fs_reset, (c == 5));
        else n_pass++;
      end
    end
    n_total++;
    if ({res_blk, mvx, mvy} !== prev) $display("FAIL abort_result_held: got %h required %h", {res_blk, mvx, mvy}, prev);
    else n_pass++;
  endtask

  task automatic test_abort_idle();
    for (int c = 0; c <= 3; c++) begin
      cyc();
      abort = (c == 0); req_valid = (c == 0); req_blk = 4'd9;
      @(negedge clk);
      n_total++;
      if ({cur_rd_en, fs_reset, req_ready} !== {1'b0, (c == 1), (c != 0)})
        $display("FAIL abort_idle c=%0d: got en/fsr/rdy=%b", c, {cur_rd_en, fs_reset, req_ready});
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_feed();
    for (int c = 0; c <= 23; c++) begin
      cyc();
      req_valid = (c == 0 || c == 10);
      req_blk   = (c == 0) ? 4'd4 : 4'd3;
      if (c == 6) reset_n = 1'b0;
      if (c == 9) reset_n = 1'b1;
      if (c == 10) exp_q.push_back({4'd3, mv_of(4'd3)});
      @(negedge clk);
      if (c >= 6 && c <= 8) begin
        n_total++;
        if ({cur_rd_en, org_rd_en, fs_ready, fs_reset, busy, done, mvx, mvy, res_blk} !== {6'b000100, 10'd0})
          $display("FAIL rst_mid c=%0d: got en=%b%b rdy=%b fsr=%b busy=%b done=%b res=%h", c, cur_rd_en,
                   org_rd_en, fs_ready, fs_reset, busy, done, {res_blk, mvx, mvy});
        else n_pass++;
      end
      if (c >= 10) begin
        n_total++;
        if (done !== (c == 21)) $display("FAIL rst_fresh_done c=%0d: got %b required %b", c, done, (c == 21));
        else n_pass++;
      end
    end
  endtask

  task automatic test_done_cycle_req();
    for (int c = 0; c <= 23; c++) begin
      cyc();
      req_valid = (c == 0 || c == 11);
      req_blk   = (c == 0) ? 4'd1 : 4'd2;
      if (c == 0)  exp_q.push_back({4'd1, mv_of(4'd1)});
      if (c == 11) exp_q.push_back({4'd2, mv_of(4'd2)});
      @(negedge clk);
      if (c >= 10 && c <= 13) begin
        n_total++;
        if ({done, cur_rd_en, fs_ready} !== {(c == 11), (c >= 11), (c >= 12)})
          $display("FAIL done_cycle_req c=%0d: got done/en/rdy=%b required %b", c, {done, cur_rd_en, fs_ready},
                   {(c == 11), (c >= 11), (c >= 12)});
        else n_pass++;
      end
      if (c == 11) begin
        n_total++;
        if (cur_addr !== 7'h10) $display("FAIL done_cycle_addr: got %h required 10", cur_addr);
        else n_pass++;
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_pass = 0; n_total = 0; last_exp = '0;
    rdy_prev = 1'b0; fs_mvx = 3'd0; fs_mvy = 3'd0;
    cur_rdata = '0; org_rdata = '0;
    test_reset();
    idle_cycles(3);
    test_single();
    idle_cycles(3);
    test_back_to_back();
    idle_cycles(3);
    test_abort();
    idle_cycles(2);
    test_abort_idle();
    idle_cycles(2);
    test_reset_mid_feed();
    idle_cycles(3);
    test_done_cycle_req();
    idle_cycles(5);
    n_total++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover: got %0d pending results required 0", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
